shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 15 +
 rtl/shift_add_mult_if.sv | 13 +
 rtl/cl_adder.sv | 26 ++
 rtl/shift_add_mult_core.sv | 71 +++++++
 rtl/shift_add_mult.sv | 30 +++
 tb/tb_shift_add_mult.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
package mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    // Counter must hold 0..Width-1 with headroom for any legal Width.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_if.sv
// Operand/result handshake bundle for the shift-add multiplier.
interface shift_add_mult_if #(parameter int Width = 8);
    logic                   valid;
    logic                   ready;
    logic [Width-1:0]       a;
    logic [Width-1:0]       b;
    logic [2*Width-1:0]     product;
    logic                   out_valid;
    logic                   out_ready;

    modport master (output valid, a, b, out_ready, input ready, product, out_valid);
    modport slave  (input valid, a, b, out_ready, output ready, product, out_valid);
endinterface

// File: rtl/cl_adder.sv
// Carry-lookahead style adder built from generate/propagate terms.
module cl_adder #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             c_i,
    output logic [Width-1:0] sum_o,
    output logic             c_o
);
    logic [Width-1:0] g, p;
    logic [Width:0]   cy;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        cy    = '0;
        cy[0] = c_i;
        for (int i = 0; i < Width; i++)
            cy[i+1] = g[i] | (p[i] & cy[i]);
    end

    assign sum_o = p ^ cy[Width-1:0];
    assign c_o   = cy[Width];
endmodule

// File: rtl/shift_add_mult_core.sv
// Sequential shift-add multiplier: one multiplier bit per BUSY cycle, LSB first.
module shift_add_mult_core
    import mult_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    shift_add_mult_if.slave    bus
);
    localparam int CW = cnt_w(Width);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [Width-1:0]     mcand;
    logic [2*Width-1:0]   prod;
    logic [2*Width-1:0]   result;
    logic [2*Width-1:0]   shifted;
    logic [Width-1:0]     addend;
    logic [Width-1:0]     sum;
    logic                 carry;
    logic                 last;

    // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
    assign addend = prod[0] ? mcand : '0;

    cl_adder #(.Width(Width)) u_add (
        .a_i   (prod[2*Width-1:Width]),
        .b_i   (addend),
        .c_i   (1'b0),
        .sum_o (sum),
        .c_o   (carry)
    );

    assign shifted = {carry, sum, prod[Width-1:1]};
    assign last    = (cnt == CW'(Width - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            prod   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (bus.valid) begin
                    mcand <= bus.a;
                    prod  <= {{Width{1'b0}}, bus.b};
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    prod <= shifted;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        // Separate result register keeps product_o stable while the next operation shifts.
                        result <= shifted;
                        state  <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = (state == IDLE) && !rst_i;
    assign bus.out_valid = (state == DONE);
    assign bus.product   = result;
endmodule

// File: rtl/shift_add_mult.sv
// Top level: flat ports bundled onto the handshake interface for the core.
module shift_add_mult #(
    parameter int Width = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic [2*Width-1:0] product_o,
    output logic               valid_o,
    input  logic               ready_i
);
    shift_add_mult_if #(.Width(Width)) bus ();

    assign bus.valid     = valid_i;
    assign bus.a         = a_i;
    assign bus.b         = b_i;
    assign bus.out_ready = ready_i;
    assign ready_o       = bus.ready;
    assign product_o     = bus.product;
    assign valid_o       = bus.out_valid;

    shift_add_mult_core #(.Width(Width)) u_core (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );
endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized bench for the shift-add multiplier at Width=8 and Width=4.
module tb_shift_add_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    shift_add_mult_if #(.Width(8)) b8 ();
    shift_add_mult_if #(.Width(4)) b4 ();

    shift_add_mult #(.Width(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(b8.valid), .ready_o(b8.ready),
        .a_i(b8.a), .b_i(b8.b), .product_o(b8.product), .valid_o(b8.out_valid),
        .ready_i(b8.out_ready)
    );

    shift_add_mult #(.Width(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(b4.valid), .ready_o(b4.ready),
        .a_i(b4.a), .b_i(b4.b), .product_o(b4.product), .valid_o(b4.out_valid),
        .ready_i(b4.out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Width=8 operation; hold = cycles ready_i stays low after valid_o rises,
    // junk = keep valid_i high with changing operands while the operation runs.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit junk);
        int k;
        int lat;
        logic [31:0] exp;
        exp = 32'(a) * 32'(b);
        k = 0;
        while (!b8.ready && k < 50) begin tick(); k++; end
        check("ready_before", 32'(b8.ready), 32'd1);
        b8.valid = 1'b1; b8.a = a; b8.b = b;
        b8.out_ready = (hold == 0);
        tick();
        if (!junk) b8.valid = 1'b0;
        check("ready_busy", 32'(b8.ready), 32'd0);
        lat = 0;
        while (!b8.out_valid && lat < 40) begin
            if (junk) begin b8.a = 8'($urandom); b8.b = 8'($urandom); end
            tick();
            lat++;
        end
        check("latency8", 32'(lat), 32'd8);
        check("product8", 32'(b8.product), exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(b8.out_valid), 32'd1);
            check("hold_product", 32'(b8.product), exp);
            check("hold_ready", 32'(b8.ready), 32'd0);
        end
        b8.out_ready = 1'b1;
        tick();
        b8.valid = 1'b0;
        check("drop_valid", 32'(b8.out_valid), 32'd0);
        check("back_idle", 32'(b8.ready), 32'd1);
    endtask

    // One Width=4 operation with ready_i randomized every cycle of DONE.
    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int k;
        int lat;
        logic [31:0] exp;
        exp = 32'(a) * 32'(b);
        k = 0;
        while (!b4.ready && k < 50) begin tick(); k++; end
        b4.valid = 1'b1; b4.a = a; b4.b = b;
        b4.out_ready = 1'($urandom);
        tick();
        b4.valid = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 40) begin
            b4.out_ready = 1'($urandom);
            tick();
            lat++;
        end
        check("latency4", 32'(lat), 32'd4);
        k = 0;
        while (b4.out_valid && k < 40) begin
            check("product4", 32'(b4.product), exp);
            b4.out_ready = 1'($urandom);
            tick();
            k++;
        end
        check("done_exit4", 32'(b4.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        int order [256];
        b8.valid = 1'b0; b8.a = '0; b8.b = '0; b8.out_ready = 1'b1;
        b4.valid = 1'b0; b4.a = '0; b4.b = '0; b4.out_ready = 1'b1;

        rst = 1'b1;
        tick(); tick();
        check("rst_ready", 32'(b8.ready), 32'd0);
        check("rst_valid", 32'(b8.out_valid), 32'd0);
        check("rst_product", 32'(b8.product), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(b8.ready), 32'd1);
        tick();

        op8(8'd13, 8'd11, 0, 1'b0);
        op8(8'hFF, 8'hFF, 0, 1'b0);
        op8(8'h00, 8'hA5, 0, 1'b0);
        op8(8'h3C, 8'h81, 5, 1'b0);
        op8(8'h9A, 8'h47, 0, 1'b1);

        // Abort mid-operation on the 4th BUSY cycle.
        b8.valid = 1'b1; b8.a = 8'h55; b8.b = 8'h33; b8.out_ready = 1'b1;
        tick();
        b8.valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_busy_ready", 32'(b8.ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(b8.ready), 32'd1);
        check("abort_product", 32'(b8.product), 32'd0);
        check("abort_valid", 32'(b8.out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b8.out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        op8(8'd7, 8'd9, 0, 1'b0);

        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++)
            op4(4'(order[i] >> 4), 4'(order[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
